square_calc: RTL and testbench

- Sequential integer squarer for the calculator datapath; it is the inverse companion of the square root unit.
- Takes an N/2-bit operand and returns its exact N-bit square using a shift-add loop that retires one operand bit per clock.
- Gated by the global FSM `state` and decoded `opcode` in the same way as the other arithmetic units, and reports completion on `done`.
- Lets the calculator check that sqrt(x)^2 <= x and supports an x^2 key.

---
 rtl/square_calc.sv | 120 ++++++++++++
 tb/tb_square_calc.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/square_calc.sv
// ============================================================================
// square_calc : sequential shift-add squarer, one operand bit per clock.
// Optional SQR_EARLY_EXIT_EN ends CALC once the remaining operand bits are zero.
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

`ifndef INPUTWIDTH
`define INPUTWIDTH 16
`endif
`ifndef EXECB
`define EXECB 3'd4
`endif
`ifndef SQRT
`define SQRT 4'd6
`endif
`ifndef SQR
`define SQR 4'd13
`endif

module square_calc #(
    parameter int N = `INPUTWIDTH
) (
    input  logic           Clock,
    input  logic           reset,
    input  logic [N/2-1:0] num_in,
    input  logic [2:0]     state,
    input  logic [3:0]     opcode,
    output logic           done,
    output logic           busy,
    output logic [N-1:0]   sq_out
);

    localparam int c_half  = N / 2;
    localparam int c_cnt_w = $clog2(c_half + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } fsm_t;

    fsm_t               r_fsm;
    logic [c_half-1:0]  r_opnd;
    logic [N-1:0]       r_mcand;
    logic [N-1:0]       r_acc;
    logic [c_cnt_w-1:0] r_cnt;

    logic               w_en;
    logic [N-1:0]       w_sum;
    logic               w_last;

    assign w_en  = (state == `EXECB) && (opcode == `SQR);
    // r_mcand holds the original operand already shifted by the current bit index
    assign w_sum = r_acc + (r_opnd[0] ? r_mcand : '0);

`ifdef SQR_EARLY_EXIT_EN
    assign w_last = (r_opnd[c_half-1:1] == '0) || (r_cnt == c_cnt_w'(1));
`else
    assign w_last = (r_cnt == c_cnt_w'(1));
`endif

    always_ff @(posedge Clock or posedge reset) begin
        if (reset) begin
            r_fsm   <= IDLE;
            r_opnd  <= '0;
            r_mcand <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            done    <= 1'b0;
            busy    <= 1'b0;
            sq_out  <= '0;
        end else begin
            case (r_fsm)
                IDLE: begin
                    done <= 1'b0;
                    if (w_en) begin
                        r_opnd  <= num_in;
                        r_mcand <= {{(N - c_half){1'b0}}, num_in};
                        r_acc   <= '0;
                        r_cnt   <= c_cnt_w'(c_half);
                        busy    <= 1'b1;
                        r_fsm   <= CALC;
                    end
                end
                CALC: begin
                    if (!w_en) begin
                        // abort: result register keeps the last completed value
                        busy  <= 1'b0;
                        r_fsm <= IDLE;
                    end else begin
                        r_acc   <= w_sum;
                        r_opnd  <= r_opnd >> 1;
                        r_mcand <= r_mcand << 1;
                        r_cnt   <= r_cnt - c_cnt_w'(1);
                        if (w_last) begin
                            sq_out <= w_sum;
                            done   <= 1'b1;
                            busy   <= 1'b0;
                            r_fsm  <= DONE;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    r_fsm <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    r_fsm <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_square_calc.sv
// Bench for square_calc: transaction-level model plus directed literal vectors.
`timescale 1ns/1ps
`default_nettype none

`ifndef EXECB
`define EXECB 3'd4
`endif
`ifndef SQRT
`define SQRT 4'd6
`endif
`ifndef SQR
`define SQR 4'd13
`endif

module tb_square_calc;

    localparam int N    = 16;
    localparam int HALF = N / 2;

`ifdef SQR_EARLY_EXIT_EN
    localparam int L0 = 1, L1 = 1, L3 = 2, L12 = 4, L128 = 8, L255 = 8;
`else
    localparam int L0 = 8, L1 = 8, L3 = 8, L12 = 8, L128 = 8, L255 = 8;
`endif

    logic            Clock  = 1'b0;
    logic            reset  = 1'b1;
    logic [HALF-1:0] num_in = '0;
    logic [2:0]      state  = 3'd0;
    logic [3:0]      opcode = 4'd0;
    logic            done;
    logic            busy;
    logic [N-1:0]    sq_out;

    int checks = 0;
    int errors = 0;
    bit run_cmp = 1'b0;

    square_calc #(.N(N)) dut (
        .Clock  (Clock),
        .reset  (reset),
        .num_in (num_in),
        .state  (state),
        .opcode (opcode),
        .done   (done),
        .busy   (busy),
        .sq_out (sq_out)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Spec-level latency: N/2 cycles, or MSB index + 1 (min 1) with early exit
    function automatic int model_lat(input int x);
`ifdef SQR_EARLY_EXIT_EN
        int m = 1;
        for (int b = 0; b < HALF; b++)
            if (x[b]) m = b + 1;
        return m;
`else
        return HALF;
`endif
    endfunction

    bit           m_active, m_done, m_en;
    int           m_cnt, m_x;
    logic [N-1:0] m_sq;

    always @(posedge Clock or posedge reset) begin
        if (reset) begin
            m_active = 1'b0;
            m_done   = 1'b0;
            m_cnt    = 0;
            m_x      = 0;
            m_sq     = '0;
        end else begin
            m_en = (state == `EXECB) && (opcode == `SQR);
            if (m_done) begin
                m_done = 1'b0;
            end else if (m_active) begin
                if (!m_en) begin
                    m_active = 1'b0;
                end else begin
                    m_cnt++;
                    if (m_cnt == model_lat(m_x)) begin
                        m_sq     = N'(m_x * m_x);
                        m_done   = 1'b1;
                        m_active = 1'b0;
                    end
                end
            end else if (m_en) begin
                m_active = 1'b1;
                m_cnt    = 0;
                m_x      = int'(num_in);
            end
        end
    end

    always @(negedge Clock) begin
        if (run_cmp && !reset) begin
            check("cmp_done",   done,   m_done);
            check("cmp_busy",   busy,   m_active);
            check("cmp_sq_out", sq_out, m_sq);
        end
    end

    task automatic enable(input logic [HALF-1:0] x);
        num_in = x;
        state  = `EXECB;
        opcode = `SQR;
    endtask

    task automatic disable_unit();
        state  = 3'd0;
        opcode = 4'd0;
    endtask

    task automatic wait_done(output int cyc, output int busy_n);
        cyc    = 0;
        busy_n = 0;
        while (cyc < 40) begin
            @(negedge Clock);
            cyc++;
            if (done) break;
            if (busy) busy_n++;
        end
        if (!done) check("done_timeout", done, 1);
    endtask

    task automatic wait_not_done();
        int k = 0;
        while (done && k < 5) begin
            @(negedge Clock);
            k++;
        end
    endtask

    task automatic run_op(input string name, input logic [HALF-1:0] x,
                          input logic [31:0] exp_sq, input int exp_lat);
        int cyc, bn;
        @(negedge Clock);
        enable(x);
        wait_done(cyc, bn);
        check({name, "_sq"},   sq_out, exp_sq);
        check({name, "_lat"},  cyc,    exp_lat + 1);
        check({name, "_busy"}, bn,     exp_lat);
        disable_unit();
        repeat (2) @(negedge Clock);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, bn, dn;
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        check("rst_done", done,   0);
        check("rst_busy", busy,   0);
        check("rst_sq",   sq_out, 0);
        reset   = 1'b0;
        run_cmp = 1'b1;

        run_op("sq12",  8'd12,  144,   L12);
        run_op("sq255", 8'd255, 65025, L255);
        run_op("sq0",   8'd0,   0,     L0);

        // back-to-back sweep with the unit left enabled
        @(negedge Clock);
        enable(8'd0);
        for (int i = 0; i < 256; i++) begin
            num_in = HALF'(i);
            wait_not_done();
            wait_done(cyc, bn);
            check("sweep_sq", sq_out, i * i);
        end
        disable_unit();
        repeat (3) @(negedge Clock);

        // abort mid-CALC keeps the previous result
        run_op("sq3", 8'd3, 9, L3);
        @(negedge Clock);
        enable(8'd200);
        repeat (3) @(negedge Clock);
        opcode = `SQRT;
        dn = 0;
        repeat (12) begin
            @(negedge Clock);
            if (done) dn++;
        end
        check("abort_no_done", dn,     0);
        check("abort_busy",    busy,   0);
        check("abort_sq",      sq_out, 9);
        disable_unit();

        // asynchronous reset between edges mid-CALC
        @(negedge Clock);
        enable(8'd100);
        repeat (3) @(negedge Clock);
        check("pre_rst_busy", busy, 1);
        #2 reset = 1'b1;
        #1;
        check("arst_done", done,   0);
        check("arst_busy", busy,   0);
        check("arst_sq",   sq_out, 0);
        @(negedge Clock);
        num_in = 8'd7;
        reset  = 1'b0;
        wait_done(cyc, bn);
        check("post_rst_sq", sq_out, 49);
        disable_unit();
        repeat (2) @(negedge Clock);

        run_op("sq1",   8'd1,   1,     L1);
        run_op("sq128", 8'd128, 16384, L128);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
